// File: rtl/fetch_stage_pkg.sv
// Purpose : shared constants, next-PC selector encoding and helpers for the
//           IF stage of the 5-stage MIPS core.
// Contents: NOP_INSTR        - encoding of the bubble instruction (sll $0,$0,0)
//           RESET_PC_DEFAULT - default PC loaded on reset
//           PC_STEP          - sequential fetch increment
//           pc_sel_e         - which source feeds the PC on the next edge
//           align_word()     - clears PC[1:0] on every PC load
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'h0000_0004;

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_STALL  = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_BRANCH = 2'd3
   } pc_sel_e;

   // Instruction addresses are word aligned; the low two bits never reach the PC.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Purpose : W-bit event counter that sticks at all-ones instead of wrapping.
// Ports   : clock  in  rising-edge clock
//           reset  in  asynchronous active-low reset (clears the count)
//           inc    in  count one event this cycle
//           count  out registered count value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Next count: advance on an event unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose : IF stage. Holds the PC, picks the next PC (PC+4, jump, taken
//           branch), drives the instruction-memory address and registers the
//           IF/ID latch. Redirects turn the IF/ID slot into a NOP bubble.
// Ports   : clock, reset          rising-edge clock, async active-low reset
//           PCWrite, IFID_Write   hazard-unit enables (0 = hold)
//           Jump, JumpTarget      J in ID and its target
//           PCSrc, BranchTarget   taken branch and its target
//           instr_addr            instruction-memory address (= PC)
//           instr_rdata           instruction-memory data (combinational read)
//           IFID_PC4/instr/valid  IF/ID pipeline latch towards ID
//           cnt_fetch/stall/flush saturating event counters for CPI debug
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 PCWrite,
   input  logic                 IFID_Write,
   input  logic                 Jump,
   input  logic [31:0]          JumpTarget,
   input  logic                 PCSrc,
   input  logic [31:0]          BranchTarget,
   output logic [31:0]          instr_addr,
   input  logic [31:0]          instr_rdata,
   output logic [31:0]          IFID_PC4,
   output logic [31:0]          IFID_instr,
   output logic                 IFID_valid,
   output logic [CNT_WIDTH-1:0] cnt_fetch,
   output logic [CNT_WIDTH-1:0] cnt_stall,
   output logic [CNT_WIDTH-1:0] cnt_flush
);

   pc_sel_e     pc_sel;
   logic [31:0] pc_plus4;
   logic [31:0] pc_d,       pc_q;
   logic [31:0] ifid_pc4_d, ifid_pc4_q;
   logic [31:0] ifid_instr_d, ifid_instr_q;
   logic        ifid_valid_d, ifid_valid_q;
   logic        fetch_inc;
   logic        stall_inc;
   logic        flush_inc;

   // Modulo-2^32 sequential address; 32'hFFFF_FFFC + 4 wraps to 0.
   assign pc_plus4 = pc_q + PC_STEP;

   // Next-PC priority: a taken branch squashes a stalled or jumping ID
   // instruction (it is wrong-path); a stall defers a pending jump until release.
   always_comb begin
      pc_sel = SEL_SEQ;
      if (PCSrc) begin
         pc_sel = SEL_BRANCH;
      end else if (!PCWrite) begin
         pc_sel = SEL_STALL;
      end else if (Jump) begin
         pc_sel = SEL_JUMP;
      end else begin
         pc_sel = SEL_SEQ;
      end
   end

   // PC, IF/ID and counter-event selection.
   always_comb begin
      pc_d         = pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      fetch_inc    = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      case (pc_sel)
         SEL_BRANCH: begin
            pc_d         = align_word(BranchTarget);
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            flush_inc    = 1'b1;
         end
         SEL_STALL: begin
            stall_inc = 1'b1;
            // IFID_Write without PCWrite is never issued by the hazard unit;
            // if it happens the slot simply reloads the held PC's instruction.
            if (IFID_Write) begin
               ifid_pc4_d   = pc_plus4;
               ifid_instr_d = instr_rdata;
               ifid_valid_d = 1'b1;
               fetch_inc    = 1'b1;
            end else begin
               ifid_pc4_d   = ifid_pc4_q;
               ifid_instr_d = ifid_instr_q;
               ifid_valid_d = ifid_valid_q;
            end
         end
         SEL_JUMP: begin
            pc_d         = align_word(JumpTarget);
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            flush_inc    = 1'b1;
         end
         SEL_SEQ: begin
            pc_d         = align_word(pc_plus4);
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = instr_rdata;
            ifid_valid_d = 1'b1;
            fetch_inc    = 1'b1;
         end
         default: begin
            pc_d         = pc_q;
            ifid_pc4_d   = ifid_pc4_q;
            ifid_instr_d = ifid_instr_q;
            ifid_valid_d = ifid_valid_q;
         end
      endcase
   end

   // PC and IF/ID pipeline latch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q         <= align_word(RESET_PC);
         ifid_pc4_q   <= 32'h0000_0000;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign instr_addr = pc_q;
   assign IFID_PC4   = ifid_pc4_q;
   assign IFID_instr = ifid_instr_q;
   assign IFID_valid = ifid_valid_q;

   sat_counter #(.W(CNT_WIDTH)) u_cnt_fetch (
      .clock (clock),
      .reset (reset),
      .inc   (fetch_inc),
      .count (cnt_fetch)
   );

   sat_counter #(.W(CNT_WIDTH)) u_cnt_stall (
      .clock (clock),
      .reset (reset),
      .inc   (stall_inc),
      .count (cnt_stall)
   );

   sat_counter #(.W(CNT_WIDTH)) u_cnt_flush (
      .clock (clock),
      .reset (reset),
      .inc   (flush_inc),
      .count (cnt_flush)
   );

endmodule
